vdp_cpu_bus_if: RTL and testbench
=================================

// Module: vdp_cpu_bus_if
// PURPOSE
//  Host-bus front end upstream of the VDP core. Samples asynchronous TMS9900-style
//  strobes csr_n/csw_n, filters glitches, and emits exactly one REQ/WRT pulse per
//  host access with latched mode/data. Captures VDP read data and holds it on the
//  cd bus while csr_n stays low. Replaces the ad-hoc io_state logic in the top level.
// PARAMETERS
//  SYNC_STAGES  2   flops in each strobe synchronizer (>=2)
//  FILT_CYCLES  3   consecutive equal synced samples required to accept a level (1..15)
//  RD_LAT       2   clk cycles from cpu_req to valid cpu_dbi (1..7)
// PORTS
//  clk        in   1   pixel/VDP clock (27 MHz domain)
//  reset      in   1   synchronous, active-high
//  csr_n      in   1   host read strobe, async, active-low
//  csw_n      in   1   host write strobe, async, active-low
//  mode       in   2   host register select (mode[1:0] -> cpu_adr[1:0])
//  cd_in      in   8   host data bus input
//  cd_out     out  8   read data toward host pads
//  cd_oe      out  1   1 = drive cd_out onto host bus
//  cpu_req    out  1   one-cycle request to VDP
//  cpu_wrt    out  1   1 = write; qualified by cpu_req
//  cpu_adr    out  16  {14'b0, mode latched at accept}
//  cpu_dbo    out  8   write data latched at accept
//  cpu_dbi    in   8   VDP read data
//  bus_err    out  1   one-cycle pulse: both strobes accepted low together
// BEHAVIOUR
//  Reset: all outputs 0, cd_out=0, state IDLE, filtered strobes = 1 (inactive).
//  Sync: each strobe through SYNC_STAGES flops, reset value 1.
//  Filter: per strobe a 4-bit counter; filtered level changes only after synced
//   input differs from it for FILT_CYCLES consecutive clks; any match clears counter.
//  FSM (on filtered rd_n/wr_n):
//   IDLE:  rd_n=0,wr_n=1 -> ISSUE(read); wr_n=0,rd_n=1 -> ISSUE(write);
//          both 0 in same cycle -> bus_err=1 one cycle, go WAIT_REL; no request.
//   ISSUE: 1 cycle. cpu_req=1, cpu_wrt=write, cpu_adr/cpu_dbo latched from mode/cd_in
//          sampled the clk IDLE exited (post-filter). write -> WAIT_REL; read -> RD_WAIT.
//   RD_WAIT: count RD_LAT cycles after ISSUE; on last, cd_out<=cpu_dbi -> WAIT_REL.
//   WAIT_REL: stay until rd_n=1 and wr_n=1 (filtered) -> IDLE. No new request
//          issued; strobe re-assert needs both released first.
//  Latency: csr/csw edge to cpu_req = SYNC_STAGES+FILT_CYCLES+1 clks (+0/1 for phase).
//  cd_oe = 1 while filtered rd_n=0 and state in RD_WAIT/WAIT_REL of a read; cd_out
//   holds last captured byte until next read capture (read before capture shows old).
//  Strobe released during RD_WAIT: capture still completes, cd_oe drops same clk
//   filtered rd_n rises; FSM goes IDLE after capture.
//  cpu_req never high two consecutive clks; cpu_wrt=0 whenever cpu_req=0.
//  reset mid-access: immediate return to IDLE, outputs to reset values; an access in
//   progress is dropped; strobes held low across reset release are ignored until seen high.
// CONFIGURATION
//  CD_BITREV_EN defined: cd_in/cd_out bit-reversed (host bit 0 = MSB, TMS9900
//   numbering): cpu_dbo[i]=cd_in[7-i], cd_out[i]=captured[7-i].
//  Not defined: straight mapping cpu_dbo=cd_in, cd_out=captured.
// TESTING
//  Write: mode=2'b01, cd_in=8'h87, csw_n low 20 clks -> exactly one cpu_req,
//   cpu_wrt=1, cpu_adr=16'h0001, cpu_dbo=8'h87 (8'hE1 with CD_BITREV_EN), at clk 6+-1.
//  Read: mode=0, cpu_dbi=8'h5A, csr_n low 20 clks -> one cpu_req, cpu_wrt=0, cd_oe=1,
//   cd_out=8'h5A from RD_LAT+1 clks after req until csr_n release + filter.
//  Glitch: csw_n low 2 clks (FILT_CYCLES=3) -> no cpu_req, state stays IDLE.
//  Conflict: csr_n and csw_n fall same clk -> bus_err one pulse, no cpu_req, idle after
//   both high.
//  Back-to-back: two writes separated by 6 clks high -> two requests, data 8'h11 then 8'h22.
//  Reset mid-read: assert reset during RD_WAIT with csr_n low -> cd_oe=0 next clk, no
//   further req until csr_n high then low again.

Source files
------------

// File: rtl/vdp_cpu_bus_if.sv
// Host-bus front end for the VDP: synchronizes and glitch-filters csr_n/csw_n, issues one
// request per host access and captures read data. Define CD_BITREV_EN for TMS9900 bit order on cd.
module vdp_cpu_bus_if #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_n,
  input  logic        csw_n,
  input  logic [1:0]  mode,
  input  logic [7:0]  cd_in,
  output logic [7:0]  cd_out,
  output logic        cd_oe,
  output logic        cpu_req,
  output logic        cpu_wrt,
  output logic [15:0] cpu_adr,
  output logic [7:0]  cpu_dbo,
  input  logic [7:0]  cpu_dbi,
  output logic        bus_err
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);
  localparam logic [2:0] RD_LAST   = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    WAIT_REL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic                   rd_s;
  logic                   wr_s;
  logic                   rd_f;
  logic                   wr_f;
  logic [3:0]             rd_cnt;
  logic [3:0]             wr_cnt;
  logic                   armed;
  logic                   accept;
  logic                   is_read;
  logic [2:0]             lat_cnt;
  logic [1:0]             adr_q;
  logic [7:0]             dbo_q;
  logic [7:0]             cap_q;
  logic [7:0]             dbo_in;

  // sync_vld marks when the chain output reflects a post-reset sample rather than the reset fill
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sync  <= '1;
      wr_sync  <= '1;
      sync_vld <= '0;
    end else begin
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0], csr_n};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], csw_n};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_f   <= 1'b1;
      rd_cnt <= '0;
    end else if (rd_s == rd_f) begin
      rd_cnt <= '0;
    end else if (rd_cnt == FILT_LAST) begin
      rd_f   <= rd_s;
      rd_cnt <= '0;
    end else begin
      rd_cnt <= rd_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_f   <= 1'b1;
      wr_cnt <= '0;
    end else if (wr_s == wr_f) begin
      wr_cnt <= '0;
    end else if (wr_cnt == FILT_LAST) begin
      wr_f   <= wr_s;
      wr_cnt <= '0;
    end else begin
      wr_cnt <= wr_cnt + 4'd1;
    end
  end

  // A strobe still held low across reset must be seen released before it can start an access
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (sync_vld[SYNC_STAGES-1] && rd_s && wr_s && rd_f && wr_f) begin
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    bus_err   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (armed) begin
          if (!rd_f && !wr_f) begin
            bus_err   = 1'b1;
            state_nxt = WAIT_REL;
          end else if (!rd_f || !wr_f) begin
            accept    = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_nxt = is_read ? RD_WAIT : WAIT_REL;
      end
      RD_WAIT: begin
        if (lat_cnt == RD_LAST) begin
          state_nxt = (rd_f && wr_f) ? IDLE : WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (rd_f && wr_f) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef CD_BITREV_EN
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  assign dbo_in = bitrev8(cd_in);
  assign cd_out = bitrev8(cap_q);
`else
  assign dbo_in = cd_in;
  assign cd_out = cap_q;
`endif

  // is_read is refreshed every IDLE cycle so a conflict never inherits a stale read flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      is_read <= 1'b0;
      lat_cnt <= '0;
      adr_q   <= '0;
      dbo_q   <= '0;
      cap_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        is_read <= armed && !rd_f && wr_f;
      end
      if (accept) begin
        adr_q <= mode;
        dbo_q <= dbo_in;
      end
      if (state == ISSUE) begin
        lat_cnt <= 3'd1;
      end else if (state == RD_WAIT && lat_cnt != RD_LAST) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      if (state == RD_WAIT && lat_cnt == RD_LAST) begin
        cap_q <= cpu_dbi;
      end
    end
  end

  assign cpu_req = (state == ISSUE);
  assign cpu_wrt = (state == ISSUE) && !is_read;
  assign cpu_adr = {14'b0, adr_q};
  assign cpu_dbo = dbo_q;
  assign cd_oe   = is_read && !rd_f && (state == RD_WAIT || state == WAIT_REL);

endmodule

// File: tb/tb_vdp_cpu_bus_if.sv
// Scoreboard bench for vdp_cpu_bus_if: stimulus pushes expected host-bus events,
// a monitor pops and compares them whenever the DUT raises cpu_req or bus_err.
`timescale 1ns/1ps
module tb_vdp_cpu_bus_if;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYCLES = 3;
  localparam int RD_LAT      = 2;
  localparam int REQ_LAT     = SYNC_STAGES + FILT_CYCLES + 1;

  localparam int OP_WR   = 0;
  localparam int OP_RD   = 1;
  localparam int OP_GLT  = 2;
  localparam int OP_CONF = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_n = 1'b1;
  logic        csw_n = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  cd_in = 8'h00;
  logic [7:0]  cpu_dbi = 8'h00;
  logic [7:0]  cd_out;
  logic        cd_oe;
  logic        cpu_req;
  logic        cpu_wrt;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_dbo;
  logic        bus_err;

  vdp_cpu_bus_if #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .csr_n  (csr_n),
    .csw_n  (csw_n),
    .mode   (mode),
    .cd_in  (cd_in),
    .cd_out (cd_out),
    .cd_oe  (cd_oe),
    .cpu_req(cpu_req),
    .cpu_wrt(cpu_wrt),
    .cpu_adr(cpu_adr),
    .cpu_dbo(cpu_dbo),
    .cpu_dbi(cpu_dbi),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    bit          wrt;
    logic [15:0] adr;
    logic [7:0]  data;
    bit          long_rd;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  // Byte as seen on the host side of the cd bus
  function automatic logic [7:0] host_view(input logic [7:0] b);
    logic [7:0] r;
    r = b;
`ifdef CD_BITREV_EN
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic failNow(input string name, input string what);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: samples 1ns after each rising edge
  initial begin : monitor
    bit         prev_req;
    bit         prev_err;
    int         pend;
    logic [7:0] pend_data;
    bit         pend_long;
    logic [7:0] last_cap;
    int         lat;
    exp_t       e;
    prev_req  = 1'b0;
    prev_err  = 1'b0;
    pend      = 0;
    pend_data = 8'h00;
    pend_long = 1'b0;
    last_cap  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_req = 1'b0;
        prev_err = 1'b0;
        pend     = 0;
        last_cap = 8'h00;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            checkOutput("rd_capture_cd_out", 32'(cd_out), 32'(pend_data));
            if (pend_long) checkOutput("rd_capture_cd_oe", 32'(cd_oe), 32'd1);
            last_cap = pend_data;
          end
        end
        checkOutput("wrt_qualified", 32'(cpu_wrt & ~cpu_req), 32'd0);
        checkOutput("req_single_cycle", 32'(cpu_req & prev_req), 32'd0);
        checkOutput("err_single_cycle", 32'(bus_err & prev_err), 32'd0);
        if (cpu_req) begin
          if (exp_q.size() == 0) begin
            failNow("unexpected_req", "cpu_req with nothing expected");
          end else begin
            e = exp_q.pop_front();
            if (e.is_err) begin
              failNow("req_kind", "got cpu_req, expected bus_err");
            end else begin
              lat = cyc - e.start_cyc;
              compared++;
              if (lat < REQ_LAT || lat > REQ_LAT + 1) begin
                mismatched++;
                $display("[TB] FAIL req_latency: got %0d, expected %0d..%0d", lat, REQ_LAT, REQ_LAT + 1);
              end
              checkOutput("req_wrt", 32'(cpu_wrt), 32'(e.wrt));
              checkOutput("req_adr", 32'(cpu_adr), 32'(e.adr));
              if (e.wrt) begin
                checkOutput("req_dbo", 32'(cpu_dbo), 32'(e.data));
              end else begin
                checkOutput("rd_old_cd_out", 32'(cd_out), 32'(last_cap));
                pend      = RD_LAT + 1;
                pend_data = e.data;
                pend_long = e.long_rd;
              end
            end
          end
        end
        if (bus_err) begin
          if (exp_q.size() == 0) begin
            failNow("unexpected_bus_err", "bus_err with nothing expected");
          end else begin
            e = exp_q.pop_front();
            if (!e.is_err) failNow("err_kind", "got bus_err, expected cpu_req");
            else checkOutput("err_kind", 32'(bus_err), 32'd1);
          end
        end
        prev_req = cpu_req;
        prev_err = bus_err;
      end
    end
  end

  // One host access: strobe(s) low for hold clks, then high for gap clks
  task automatic applyStimulus(input int kind, input int hold, input int gap,
                               input logic [1:0] m, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    mode        = m;
    e.is_err    = (kind == OP_CONF);
    e.wrt       = (kind == OP_WR);
    e.adr       = {14'b0, m};
    e.data      = host_view(d);
    e.long_rd   = (hold >= 8);
    e.start_cyc = cyc;
    case (kind)
      OP_WR: begin
        cd_in = d;
        csw_n = 1'b0;
        exp_q.push_back(e);
      end
      OP_RD: begin
        cpu_dbi = d;
        csr_n   = 1'b0;
        exp_q.push_back(e);
      end
      OP_GLT: begin
        if ($urandom_range(0, 1) == 1) csw_n = 1'b0;
        else csr_n = 1'b0;
      end
      default: begin
        csr_n = 1'b0;
        csw_n = 1'b0;
        exp_q.push_back(e);
      end
    endcase
    repeat (hold) @(negedge clk);
    csr_n = 1'b1;
    csw_n = 1'b1;
    repeat (gap) @(negedge clk);
    checkOutput("idle_cd_oe", 32'(cd_oe), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    bit   found;
    int   kind;
    int   hold;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_cpu_req", 32'(cpu_req), 32'd0);
    checkOutput("rst_cpu_wrt", 32'(cpu_wrt), 32'd0);
    checkOutput("rst_cpu_adr", 32'(cpu_adr), 32'd0);
    checkOutput("rst_cpu_dbo", 32'(cpu_dbo), 32'd0);
    checkOutput("rst_cd_out", 32'(cd_out), 32'd0);
    checkOutput("rst_cd_oe", 32'(cd_oe), 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    repeat (6) @(negedge clk);

    $display("[TB] directed: write, read, glitch, conflict, back-to-back");
    applyStimulus(OP_WR, 20, 8, 2'b01, 8'h87);
    applyStimulus(OP_RD, 20, 8, 2'b00, 8'h5A);
    applyStimulus(OP_GLT, FILT_CYCLES - 1, 8, 2'b00, 8'h00);
    applyStimulus(OP_CONF, 8, 8, 2'b00, 8'h00);
    applyStimulus(OP_WR, 4, 6, 2'b10, 8'h11);
    applyStimulus(OP_WR, 4, 6, 2'b11, 8'h22);
    applyStimulus(OP_WR, FILT_CYCLES, 6, 2'b01, 8'h3C);
    applyStimulus(OP_RD, FILT_CYCLES, 6, 2'b10, 8'hA5);

    $display("[TB] random accesses");
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        OP_GLT:  hold = int'($urandom_range(1, FILT_CYCLES - 1));
        OP_CONF: hold = int'($urandom_range(3, 10));
        default: hold = int'($urandom_range(FILT_CYCLES, 20));
      endcase
      applyStimulus(kind, hold, int'($urandom_range(6, 10)),
                    2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    $display("[TB] directed: reset during read wait");
    @(negedge clk);
    mode        = 2'b00;
    cpu_dbi     = 8'hC3;
    csr_n       = 1'b0;
    e.is_err    = 1'b0;
    e.wrt       = 1'b0;
    e.adr       = 16'h0000;
    e.data      = host_view(8'hC3);
    e.long_rd   = 1'b1;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cpu_req) found = 1'b1;
    end
    if (!found) failNow("rst_rd_req_timeout", "no cpu_req within 20 clks");
    else checkOutput("rst_rd_req_seen", 32'(cpu_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_mid_cd_oe", 32'(cd_oe), 32'd0);
    checkOutput("rst_mid_cd_out", 32'(cd_out), 32'd0);
    checkOutput("rst_mid_cpu_req", 32'(cpu_req), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("rst_held_cd_oe", 32'(cd_oe), 32'd0);
    csr_n = 1'b1;
    repeat (8) @(negedge clk);
    applyStimulus(OP_RD, 12, 8, 2'b11, 8'h96);
    applyStimulus(OP_WR, 10, 8, 2'b10, 8'h4B);

    repeat (10) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
